// File: rtl/conv33_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv33_pkg
// Description : Shared definitions for the 3x3 multi-channel convolution
//               engine: width derivation, packed-bus unpacking and the
//               round / ReLU / saturate requantisation step.
// Revision    : 1.0 - initial release
// ============================================================================
package conv33_pkg;

    // Default configuration, used for the reference width localparams below.
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH   = 32;
    localparam int DEF_SCALE_WIDTH = 32;

    // Helper working widths. DATA_WIDTH <= MAX_DW and the scaled product must
    // fit in WIDE_W with headroom for the rounding add.
    localparam int MAX_DW = 32;
    localparam int BUS_W  = 9 * MAX_DW;
    localparam int WIDE_W = 128;
    localparam int RES_W  = 32;

    function automatic int prod_w(input int dw);
        return 2 * dw;
    endfunction

    // Nine terms need 4 extra bits of growth.
    function automatic int tree_w(input int dw);
        return 2 * dw + 4;
    endfunction

    function automatic int biased_w(input int aw);
        return aw + 1;
    endfunction

    function automatic int scaled_w(input int aw, input int sw);
        return aw + 1 + sw;
    endfunction

    localparam int PROD_W   = prod_w(DEF_DATA_WIDTH);
    localparam int TREE_W   = tree_w(DEF_DATA_WIDTH);
    localparam int BIASED_W = biased_w(DEF_ACC_WIDTH);
    localparam int SCALED_W = scaled_w(DEF_ACC_WIDTH, DEF_SCALE_WIDTH);

    // Extract element k (dw bits wide) from a 9-element packed bus. The caller
    // zero-extends its bus to BUS_W and truncates the result to dw bits.
    function automatic logic [MAX_DW-1:0] unpack9(input logic [BUS_W-1:0] bus,
                                                  input int k, input int dw);
        logic [BUS_W-1:0]  sh;
        logic [MAX_DW-1:0] mask;
        sh   = bus >> (k * dw);
        mask = {MAX_DW{1'b1}} >> (MAX_DW - dw);
        return sh[MAX_DW-1:0] & mask;
    endfunction

    // Round half-up, arithmetic shift right, optional ReLU, then saturate to
    // a signed dw-bit range. The result is sign-correct in the low dw bits.
    function automatic logic signed [RES_W-1:0] round_shift_sat(
        input logic signed [WIDE_W-1:0] p,
        input int                       shift,
        input int                       dw,
        input logic                     relu
    );
        logic signed [WIDE_W-1:0] one;
        logic signed [WIDE_W-1:0] r;
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        one    = '0;
        one[0] = 1'b1;
        r      = (p + (one <<< (shift - 1))) >>> shift;
        if (relu && r[WIDE_W-1]) begin
            r = '0;
        end
        hi = (one <<< (dw - 1)) - one;
        lo = -(one <<< (dw - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r[RES_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv33_tree.sv
`default_nettype none
// ============================================================================
// Module      : conv33_tree
// Description : Registered 9-input signed adder tree. Three row sums are
//               combined into one result, registered with a valid flag.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               in_valid       - in_prod holds a valid set of terms
//               in_prod        - 9 signed IN_W terms, element k at k*IN_W
//               sum / out_valid- registered sum and its valid flag
// Revision    : 1.0 - initial release
// ============================================================================
module conv33_tree #(
    parameter int IN_W  = 16,
    parameter int OUT_W = IN_W + 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [9*IN_W-1:0]       in_prod,
    output logic signed [OUT_W-1:0] sum,
    output logic                    out_valid
);

    logic signed [OUT_W-1:0] w_term [9];
    logic signed [OUT_W-1:0] w_part [3];
    logic signed [OUT_W-1:0] w_sum;

    generate
        for (genvar k = 0; k < 9; k++) begin : g_ext
            assign w_term[k] = OUT_W'(signed'(in_prod[k*IN_W +: IN_W]));
        end
        for (genvar j = 0; j < 3; j++) begin : g_row
            assign w_part[j] = w_term[3*j] + w_term[3*j+1] + w_term[3*j+2];
        end
    endgenerate

    assign w_sum = w_part[0] + w_part[1] + w_part[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum <= w_sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv33_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : conv33_mac_pipe
// Description : Pipelined 3x3 convolution engine. Accumulates 1..MAX_IN_CH
//               window/weight beats per group, adds bias, requantises with
//               round half-up, optional ReLU and saturation.
//               Pipeline: S1 multiply, S2 adder tree, S3 accumulate,
//               S4a bias add, S4b scale multiply, S5 round/saturate.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               in_valid/in_data/in_weight - one 3x3 beat per cycle
//               cfg_in_ch           - beats per group (0 -> 1, clamped)
//               bias/scale/relu_en  - sampled on the last beat of a group
//               clear               - abort the partial group, drop beat
//               result/out_valid    - requantised pixel and 1-cycle strobe
//               busy                - partial group or data in flight
// Revision    : 1.0 - initial release
// ============================================================================
module conv33_mac_pipe
    import conv33_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int BIAS_WIDTH  = 32,
    parameter int SCALE_WIDTH = 32,
    parameter int SHIFT       = 16,
    parameter int MAX_IN_CH   = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [9*DATA_WIDTH-1:0]            in_data,
    input  logic [9*DATA_WIDTH-1:0]            in_weight,
    input  logic [$clog2(MAX_IN_CH+1)-1:0]     cfg_in_ch,
    input  logic [BIAS_WIDTH-1:0]              bias,
    input  logic [SCALE_WIDTH-1:0]             scale,
    input  logic                               relu_en,
    input  logic                               clear,
    output logic [DATA_WIDTH-1:0]              result,
    output logic                               out_valid,
    output logic                               busy
);

    localparam int c_ch_w     = $clog2(MAX_IN_CH + 1);
    localparam int c_prod_w   = prod_w(DATA_WIDTH);
    localparam int c_tree_w   = tree_w(DATA_WIDTH);
    localparam int c_biased_w = biased_w(ACC_WIDTH);
    localparam int c_scaled_w = scaled_w(ACC_WIDTH, SCALE_WIDTH);
    localparam logic [c_ch_w-1:0] c_one_ch = c_ch_w'(1);
    localparam logic [c_ch_w-1:0] c_max_ch = c_ch_w'(MAX_IN_CH);

    // ------------------------------------------------------------------
    // Channel counter: group size is latched on the first beat of a group
    // ------------------------------------------------------------------
    logic [c_ch_w-1:0] r_ch_cnt;
    logic [c_ch_w-1:0] r_in_ch;
    logic [c_ch_w-1:0] w_cfg_eff;
    logic [c_ch_w-1:0] w_grp_ch;
    logic              w_first;
    logic              w_last;
    logic              w_accept;

    always_comb begin
        w_cfg_eff = cfg_in_ch;
        if (cfg_in_ch == '0) begin
            w_cfg_eff = c_one_ch;
        end else if (cfg_in_ch > c_max_ch) begin
            w_cfg_eff = c_max_ch;
        end
    end

    assign w_accept = in_valid & ~clear;
    assign w_first  = (r_ch_cnt == '0);
    // The live cfg value only matters at a group start.
    assign w_grp_ch = w_first ? w_cfg_eff : r_in_ch;
    assign w_last   = (r_ch_cnt == (w_grp_ch - c_one_ch));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_cnt <= '0;
            r_in_ch  <= c_one_ch;
        end else if (clear) begin
            r_ch_cnt <= '0;
        end else if (in_valid) begin
            if (w_first) begin
                r_in_ch <= w_cfg_eff;
            end
            r_ch_cnt <= w_last ? '0 : (r_ch_cnt + c_one_ch);
        end
    end

    // ------------------------------------------------------------------
    // S1: nine full-precision products
    // ------------------------------------------------------------------
    logic [9*c_prod_w-1:0] w_prod;

    generate
        for (genvar k = 0; k < 9; k++) begin : g_mul
            logic signed [DATA_WIDTH-1:0] w_d;
            logic signed [DATA_WIDTH-1:0] w_w;
            assign w_d = DATA_WIDTH'(unpack9(BUS_W'(in_data), k, DATA_WIDTH));
            assign w_w = DATA_WIDTH'(unpack9(BUS_W'(in_weight), k, DATA_WIDTH));
            assign w_prod[k*c_prod_w +: c_prod_w] = c_prod_w'(w_d) * c_prod_w'(w_w);
        end
    endgenerate

    logic [9*c_prod_w-1:0]  r_prod;
    logic                   r_s1_vld;
    logic                   r_s1_first;
    logic                   r_s1_last;
    logic [BIAS_WIDTH-1:0]  r_s1_bias;
    logic [SCALE_WIDTH-1:0] r_s1_scale;
    logic                   r_s1_relu;

    // Group parameters ride along with every beat; only the last beat's
    // copy is ever used, which is what samples them on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod     <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_bias  <= '0;
            r_s1_scale <= '0;
            r_s1_relu  <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_prod     <= w_prod;
                r_s1_first <= w_first;
                r_s1_last  <= w_last;
                r_s1_bias  <= bias;
                r_s1_scale <= scale;
                r_s1_relu  <= relu_en;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: adder tree plus aligned sideband
    // ------------------------------------------------------------------
    logic signed [c_tree_w-1:0] w_s2_sum;
    logic                       w_s2_vld;
    logic                       r_s2_first;
    logic                       r_s2_last;
    logic [BIAS_WIDTH-1:0]      r_s2_bias;
    logic [SCALE_WIDTH-1:0]     r_s2_scale;
    logic                       r_s2_relu;

    conv33_tree #(
        .IN_W  (c_prod_w),
        .OUT_W (c_tree_w)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_s1_vld),
        .in_prod   (r_prod),
        .sum       (w_s2_sum),
        .out_valid (w_s2_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_bias  <= '0;
            r_s2_scale <= '0;
            r_s2_relu  <= 1'b0;
        end else if (r_s1_vld) begin
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_bias  <= r_s1_bias;
            r_s2_scale <= r_s1_scale;
            r_s2_relu  <= r_s1_relu;
        end
    end

    // ------------------------------------------------------------------
    // S3: accumulator. A first beat loads, so beats of an aborted group
    // still draining through S1/S2 are overwritten by the next group.
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_grp;
    logic                        r_grp_vld;
    logic [BIAS_WIDTH-1:0]       r_grp_bias;
    logic [SCALE_WIDTH-1:0]      r_grp_scale;
    logic                        r_grp_relu;
    logic signed [ACC_WIDTH-1:0] w_acc_next;

    assign w_acc_next = (r_s2_first ? '0 : r_acc) + ACC_WIDTH'(w_s2_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_grp       <= '0;
            r_grp_vld   <= 1'b0;
            r_grp_bias  <= '0;
            r_grp_scale <= '0;
            r_grp_relu  <= 1'b0;
        end else begin
            r_grp_vld <= w_s2_vld & r_s2_last;
            if (w_s2_vld) begin
                r_acc <= w_acc_next;
                if (r_s2_last) begin
                    r_grp       <= w_acc_next;
                    r_grp_bias  <= r_s2_bias;
                    r_grp_scale <= r_s2_scale;
                    r_grp_relu  <= r_s2_relu;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S4a: bias add, S4b: scale multiply
    // ------------------------------------------------------------------
    logic signed [c_biased_w-1:0] r_biased;
    logic [SCALE_WIDTH-1:0]       r_s4_scale;
    logic                         r_s4_relu;
    logic                         r_s4_vld;
    logic signed [c_scaled_w-1:0] r_p;
    logic                         r_p_relu;
    logic                         r_p_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_biased   <= '0;
            r_s4_scale <= '0;
            r_s4_relu  <= 1'b0;
            r_s4_vld   <= 1'b0;
            r_p        <= '0;
            r_p_relu   <= 1'b0;
            r_p_vld    <= 1'b0;
        end else begin
            r_s4_vld <= r_grp_vld;
            if (r_grp_vld) begin
                r_biased   <= c_biased_w'(r_grp) + c_biased_w'(signed'(r_grp_bias));
                r_s4_scale <= r_grp_scale;
                r_s4_relu  <= r_grp_relu;
            end
            r_p_vld <= r_s4_vld;
            if (r_s4_vld) begin
                r_p      <= c_scaled_w'(r_biased) * c_scaled_w'(signed'(r_s4_scale));
                r_p_relu <= r_s4_relu;
            end
        end
    end

    // ------------------------------------------------------------------
    // S5: round, ReLU, saturate
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_out_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= r_p_vld;
            if (r_p_vld) begin
                r_result <= DATA_WIDTH'(round_shift_sat(WIDE_W'(r_p), SHIFT,
                                                        DATA_WIDTH, r_p_relu));
            end
        end
    end

    assign result    = r_result;
    assign out_valid = r_out_vld;
    assign busy      = (r_ch_cnt != '0) | r_s1_vld | w_s2_vld | r_grp_vld |
                       r_s4_vld | r_p_vld | r_out_vld;

endmodule
`default_nettype wire

// File: doc/conv33_mac_pipe.md
# conv33_mac_pipe

Pipelined, parametrised 3x3 convolution engine with multi-channel accumulation, bias, fixed-point requantisation, optional ReLU and output saturation. It accepts one 3x3 window plus its 9 weights per cycle, sums 1..MAX_IN_CH input-channel beats into one output pixel, and emits one saturated DATA_WIDTH result per channel group. It sits between the line-buffer/window generator and the feature-map writer, and is the multi-channel successor of the single-cycle 3x3 calculator.

## Interface
- DATA_WIDTH, 8, signed width of activations, weights and result
- ACC_WIDTH, 32, signed accumulator width; must be ≥ 2*DATA_WIDTH+4+clog2(MAX_IN_CH)
- BIAS_WIDTH, 32, signed bias width; must be ≤ ACC_WIDTH
- SCALE_WIDTH, 32, signed scale width
- SHIFT, 16, right-shift after scaling (scale is Q.SHIFT); must be ≥ 1
- MAX_IN_CH, 64, maximum channels per group
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  window/weight beat present this cycle
- in_data  in  9*DATA_WIDTH  window, element k = row*3+col at bits [k*DATA_WIDTH +: DATA_WIDTH]
- in_weight  in  9*DATA_WIDTH  weights, same packing
- cfg_in_ch  in  clog2(MAX_IN_CH+1)  channels per group; 0 is treated as 1; values above MAX_IN_CH are clamped to MAX_IN_CH
- bias  in  BIAS_WIDTH  per-output-channel bias, sampled on the last beat of a group
- scale  in  SCALE_WIDTH  requant multiplier, sampled on the last beat of a group
- relu_en  in  1  clamp negatives to 0, sampled on the last beat of a group
- clear  in  1  synchronous abort of the partial group
- result  out  DATA_WIDTH  requantised output pixel
- out_valid  out  1  one-cycle strobe, result valid
- busy  out  1  high while a group is partially accumulated or any pipeline stage holds valid data

## Operation
- No backpressure: a beat is accepted on every cycle with in_valid=1. Gaps between beats of a group are allowed.
- Channel counter ch_cnt, 0..cfg_in_ch-1.
  - cfg_in_ch is latched when a group starts (first beat with ch_cnt=0).
  - A beat with ch_cnt = latched_in_ch-1 is the last beat of its group; ch_cnt then wraps to 0.
- S1: 9 products (2*DATA_WIDTH, full precision) are registered.
- S2: a 9-input adder tree sums them (2*DATA_WIDTH+4 bits), registered.
- S3: the accumulator loads the tree sum on the first beat of a group and adds it on later beats.
  - On the last beat, acc+sum goes to the group register together with bias, scale and relu_en.
  - The accumulator does not wrap; the parameter rule guarantees no overflow.
- S4: biased = group + sign-extended bias, ACC_WIDTH+1 bits. Registered product p = biased*scale, ACC_WIDTH+1+SCALE_WIDTH bits.
- S5: in order:
  - Round half-up: r = (p + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift.
  - If relu_en and r<0, then r=0.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register result and assert out_valid.
- clear: ch_cnt←0 and the partial accumulation is discarded.
  - Groups already past S3 still complete.
  - A beat presented with clear in the same cycle is dropped.
- Reset values: result=0, out_valid=0, busy=0, ch_cnt=0, accumulator=0, all stage valids=0.
- Reset mid-operation: all in-flight data is lost and no out_valid follows.

## Timing
- Latency: the last beat is accepted at edge N; out_valid=1 in the cycle after edge N+5, i.e. 5 cycles.
- Throughput: one beat per cycle. With cfg_in_ch=1, one result per cycle back-to-back.
- Between groups, the first beat of a new group may directly follow the last beat of the previous one; no bubble.
- Changes to cfg_in_ch mid-group take effect at the next group start.
- Changes to bias/scale/relu_en are only seen on last beats.
- busy deasserts the cycle after the final out_valid when no partial group remains.

## Structure
- Package conv33_pkg holds:
  - Width-derivation localparams: PROD_W, TREE_W, BIASED_W, SCALED_W.
  - A round_shift_sat function parametrised by SHIFT and DATA_WIDTH.
  - An unpack helper for the 9-element packed buses.
- Sub-module conv33_tree: registered 9-input signed adder tree (S2), reusable by later depthwise blocks.
- Top level holds the S1 multipliers, channel counter, accumulator, requant stages and valid pipeline.

## Test plan
- All data=1, weights=1, cfg_in_ch=1, bias=0, scale=65536, relu_en=0, one beat → result=9 exactly 5 cycles later, out_valid high for 1 cycle.
- cfg_in_ch=3, same beats with 2-cycle gaps, bias=5 → single result 32; no out_valid after beats 1 and 2.
- data=127, weights=127, cfg_in_ch=1, scale=65536 → 127 (saturated). Weights=-128 with relu_en=0 → -128; with relu_en=1 → 0.
- Rounding: a single centre product of 1 (rest 0), scale=32768 → 1. Product -1 → 0. Product 3, scale=32768 → 2.
- Back-to-back cfg_in_ch=1 beats with products summing to 1,2,3,4 → results 1,2,3,4 on consecutive cycles.
- cfg_in_ch=4:
  - After 2 beats, assert clear, then 4 fresh beats of sum 1 → result 4.
  - Assert rst between beat 3 and beat 4 → no out_valid; all outputs read 0.
